// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, branch/jump flushes and MDU waits.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state_o,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  localparam int WAIT_W = $clog2(MDU_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              redirect;
  logic              wait_last;

  // Register 0 is hard-wired zero, so a load "into" it never creates a dependency.
  assign load_use  = ex_mem_read && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign redirect  = branch_taken || jump;
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign state_o   = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      state       <= next_state;
      wait_cnt    <= (state == MDU_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      // A done on the final cycle is a normal completion, not a timeout.
      if (state == MDU_WAIT && !mdu_done && wait_last)
        mdu_timeout <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (redirect)       next_state = FLUSH;
        else if (load_use)  next_state = LOAD_STALL;
        else if (mdu_start) next_state = MDU_WAIT;
      end
      LOAD_STALL: next_state = redirect ? FLUSH : RUN;
      FLUSH:      next_state = redirect ? FLUSH : RUN;
      MDU_WAIT: begin
        // Pipeline is frozen here, so branch/jump are deliberately ignored.
        if (mdu_done || wait_last) next_state = RUN;
      end
      default:    next_state = RUN;
    endcase
  end

  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    id_ex_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    case (state)
      LOAD_STALL: begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_flush  = 1'b1;
      end
      MDU_WAIT: begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_enable = 1'b0;
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // flush_cnt counts every cycle whose next state is FLUSH: entries plus holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == LOAD_STALL || state == MDU_WAIT)
        stall_cnt <= sat_inc(stall_cnt);
      if (next_state == FLUSH)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
